key_schedule_seq: RTL
=====================

KEY_SCHEDULE_SEQ -- requirements
Module: key_schedule_seq

Interface
REQ-001 The block SHALL have parameter n, default `N, meaning word size in bits (16, 24, 32, 48 or 64).
REQ-002 The block SHALL have parameter m, default `M, meaning number of key words (2, 3 or 4, legal for n per Simon).
REQ-003 Port clk  input  1  is the single clock; all state is updated on its rising edge.
REQ-004 Port rst  input  1  is the reset: asynchronous and active-high.
REQ-005 Port start  input  1  is a one-cycle request to load key and begin a schedule.
REQ-006 Port key  input  n*m  is the master key; word j = key[n*(j+1)-1 -: n], word 0 is used first.
REQ-007 Port rk  output  n  is the current round key.
REQ-008 Port rk_round  output  8  is the round index of rk.
REQ-009 Port rk_valid  output  1  is high when rk is valid.
REQ-010 Port rk_ready  input  1  is high when the consumer accepts rk.
REQ-011 Port busy  output  1  is high from the load cycle until the last round key is accepted.
REQ-012 Port done  output  1  is a one-cycle pulse after the last round key is accepted.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE + start=1: window W[0..m-1] <= key words 0..m-1, round <= 0, go to RUN; rk_valid rises the next cycle.
REQ-015 start SHALL be ignored in RUN and DONE.
REQ-016 In RUN: rk = W[0], rk_round = round, rk_valid = 1.
REQ-017 rk and rk_round SHALL stay stable while rk_valid=1 and rk_ready=0.
REQ-018 Handshake: transfer occurs only when rk_valid and rk_ready are both 1.
REQ-019 On transfer: W[j] <= W[j+1] for j<m-1, W[m-1] <= new, round <= round+1.
REQ-020 new = ~W[0] ^ t ^ ROR1(t) ^ z[idx] ^ 3, where t = ROR3(W[m-1]) ^ (m==4 ? W[1] : 0).
REQ-021 idx = (round+m-m) mod 62 = round mod 62, using z sequence z0..z4 selected per (n,m) as in the Simon spec.
REQ-022 ROR SHALL be a rotate right within n bits; z[idx] and the constant 3 SHALL be zero-extended to n bits.
REQ-023 Round count T SHALL be: 32/64→32, 48/72→36, 48/96→36, 64/96→42, 64/128→44, 96/96→52, 96/144→54, 128/128→68, 128/192→69, 128/256→72 (block/key bits).
REQ-024 A transfer with round=T-1 SHALL go to DONE, with rk_valid=0 the next cycle.
REQ-025 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-026 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-027 Throughput SHALL be one round key per cycle while rk_ready is held at 1; there SHALL be no bubbles between rounds.
REQ-028 An unsupported (n,m) combination SHALL be rejected at elaboration.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, rk=0, rk_round=0, rk_valid=0, busy=0, done=0 and W=0.
REQ-030 Reset mid-schedule SHALL abandon the schedule; there SHALL be no partial output after deassertion.
REQ-031 The first start SHALL be honoured in the first clock after rst deasserts.

Configuration
REQ-032 Macro KEY_SCHED_ABORT_EN: when defined, the block SHALL add port abort  input  1.
REQ-033 With KEY_SCHED_ABORT_EN, abort=1 in RUN or DONE SHALL cause the next cycle to be IDLE with rk_valid=0 and busy=0, no done pulse, and abort overriding a simultaneous transfer.
REQ-034 Without KEY_SCHED_ABORT_EN, the abort port SHALL be absent and schedules SHALL always run to completion.

Verification
REQ-035 n=16, m=4, key=0x1918_1110_0908_0100, start, rk_ready=1 -> rk 0x0100, 0x0908, 0x1110, 0x1918 on consecutive cycles, 32 keys in total, then done pulse.
REQ-036 The same run SHALL match a bit-accurate Simon32/64 key-schedule model for rounds 4..31; using the keys to encrypt 0x6565_6877 SHALL yield 0xc69b_e9bb.
REQ-037 rk_ready toggled randomly -> rk and rk_round SHALL be held while stalled, with no key skipped or repeated; rk_round SHALL be 0..T-1 in order.
REQ-038 A start pulse during RUN at round 5 -> the pulse SHALL be ignored and the sequence SHALL be unchanged.
REQ-039 rst asserted at round 10 -> outputs SHALL be 0 immediately; a new start SHALL restart at round 0 with W reloaded.
REQ-040 With KEY_SCHED_ABORT_EN, abort at round 7 together with a transfer -> next cycle IDLE with no done pulse; a subsequent start SHALL give a full T-key run.

Source files
------------

// File: rtl/key_schedule_seq.sv
// key_schedule_seq: sequential Simon key-schedule generator.
// Loads an m-word master key on start, then streams T round keys over a
// valid/ready handshake, one per cycle while the consumer is ready.
// After the last key is accepted, done pulses for one cycle.
// Parameters: n = word size (16/24/32/48/64), m = key words (2/3/4).
// Defaults come from the `N / `M macros, which fall back to Simon32/64.
// Optional macro KEY_SCHED_ABORT_EN adds the abort input.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, key          load request and master key (word 0 in key[n-1:0])
//   rk, rk_round        current round key and its round index
//   rk_valid, rk_ready  round-key handshake
//   abort               (KEY_SCHED_ABORT_EN only) drop the schedule
//   busy, done          schedule in progress / one-cycle completion pulse
`ifndef N
`define N 16
`endif
`ifndef M
`define M 4
`endif

module key_schedule_seq #(
   parameter int unsigned n = `N,
   parameter int unsigned m = `M
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [n*m-1:0] key,
   output logic [n-1:0]   rk,
   output logic [7:0]     rk_round,
   output logic           rk_valid,
   input  logic           rk_ready,
`ifdef KEY_SCHED_ABORT_EN
   input  logic           abort,
`endif
   output logic           busy,
   output logic           done
);

   // Round count per (n,m); 0 marks an unsupported combination.
   localparam int unsigned T =
      (n == 16 && m == 4) ? 32 :
      (n == 24 && m == 3) ? 36 :
      (n == 24 && m == 4) ? 36 :
      (n == 32 && m == 3) ? 42 :
      (n == 32 && m == 4) ? 44 :
      (n == 48 && m == 2) ? 52 :
      (n == 48 && m == 3) ? 54 :
      (n == 64 && m == 2) ? 68 :
      (n == 64 && m == 3) ? 69 :
      (n == 64 && m == 4) ? 72 : 0;

   localparam int unsigned Z_SEL =
      (n == 16 && m == 4) ? 0 :
      (n == 24 && m == 3) ? 0 :
      (n == 24 && m == 4) ? 1 :
      (n == 32 && m == 3) ? 2 :
      (n == 32 && m == 4) ? 3 :
      (n == 48 && m == 2) ? 2 :
      (n == 48 && m == 3) ? 3 :
      (n == 64 && m == 2) ? 2 :
      (n == 64 && m == 3) ? 3 : 4;

   // z sequences stored with z[0] in the MSB, so z[i] = Z[61-i].
   localparam logic [61:0] Z0 = 62'b1111101000_1001010110_0001110011_0111110100_0100101011_0000111001_10;
   localparam logic [61:0] Z1 = 62'b1000111011_1110010011_0000101101_0100011101_1111001001_1000010110_10;
   localparam logic [61:0] Z2 = 62'b1010111101_1100000011_0100100110_0010100001_0001111110_0101101100_11;
   localparam logic [61:0] Z3 = 62'b1101101110_1011000110_0101111000_0001001000_1010011100_1101000011_11;
   localparam logic [61:0] Z4 = 62'b1101000111_1001101011_0110001000_0001011100_0011001010_0100111011_11;

   localparam logic [61:0] Z_SEQ = (Z_SEL == 0) ? Z0 : (Z_SEL == 1) ? Z1 :
                                   (Z_SEL == 2) ? Z2 : (Z_SEL == 3) ? Z3 : Z4;
   localparam logic [7:0]  LAST  = 8'(T - 1);

   if (T == 0) begin : g_bad_cfg
      $error("key_schedule_seq: unsupported (n,m) combination");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         r_state;
   logic [n-1:0]   r_win [m];
   logic [7:0]     r_round;
   logic           r_valid;
   logic           r_busy;
   logic           r_done;

   logic           w_xfer;
   logic           w_abort;
   logic [n-1:0]   w_t;
   logic [n-1:0]   w_new;
   logic [5:0]     w_idx;
   logic           w_zbit;

`ifdef KEY_SCHED_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_xfer = r_valid & rk_ready;

   // Next key word from the current window; z index is round mod 62.
   assign w_t    = {r_win[m-1][2:0], r_win[m-1][n-1:3]} ^ ((m == 4) ? r_win[1] : '0);
   assign w_idx  = (r_round >= 8'd62) ? 6'(r_round - 8'd62) : 6'(r_round);
   assign w_zbit = Z_SEQ[6'd61 - w_idx];
   assign w_new  = ~r_win[0] ^ w_t ^ {w_t[0], w_t[n-1:1]} ^ n'(w_zbit) ^ n'(3);

   // Control FSM and key window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_round <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         for (int j = 0; j < m; j++) r_win[j] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  for (int j = 0; j < m; j++) r_win[j] <= key[n*j +: n];
                  r_round <= '0;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_abort) begin
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (w_xfer) begin
                  for (int j = 0; j < m - 1; j++) r_win[j] <= r_win[j+1];
                  r_win[m-1] <= w_new;
                  r_round    <= r_round + 8'd1;
                  if (r_round == LAST) begin
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign rk       = r_win[0];
   assign rk_round = r_round;
   assign rk_valid = r_valid;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule
